// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the two-master GPIO/UART peripheral port arbiter.
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] EXEC_STATE_DEFAULT = 3'd6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) gnt_id = ~last_grant;
    else              gnt_id = req1;
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Arbitrates the core LSU (0) and debug loader (1) onto the single peripheral
// port, sequencing each access as IDLE -> ISSUE -> WAIT -> RESP.
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WINDOW_BITS = 4,
  parameter logic [2:0]  EXEC_STATE  = EXEC_STATE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        uns0,
  input  logic        uns1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [2:0]  per_state,
  output logic        per_enabled,
  output logic        per_load_enable,
  output logic        per_store_enable,
  output logic        per_is_lb,
  output logic        per_is_lbu,
  output logic        per_is_lh,
  output logic        per_is_lhu,
  output logic        per_is_lw,
  output logic        per_is_sb,
  output logic        per_is_sh,
  output logic        per_is_sw,
  output logic [31:0] per_address,
  output logic [31:0] per_data_in,
  input  logic [31:0] per_data_out
);

  localparam logic [31:0] WIN_MASK = ~((32'd1 << WINDOW_BITS) - 32'd1);

  state_t      state, state_next;
  logic        gnt_valid, gnt_id, last_grant;
  logic        cur_id, cur_we, cur_uns, cur_err;
  logic [1:0]  cur_size;
  logic        sel_we, sel_uns, sel_in_win;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    sel_we     = gnt_id ? we1    : we0;
    sel_size   = gnt_id ? size1  : size0;
    sel_uns    = gnt_id ? uns1   : uns0;
    sel_addr   = gnt_id ? addr1  : addr0;
    sel_wdata  = gnt_id ? wdata1 : wdata0;
    sel_in_win = (sel_addr & WIN_MASK) == BASE_ADDR;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (gnt_valid) state_next = sel_in_win ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The winner's rdata is cleared at grant so stores and errors return 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      cur_size    <= SZ_B;
      cur_uns     <= 1'b0;
      cur_err     <= 1'b0;
      per_address <= '0;
      per_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      if (state == ST_IDLE && gnt_valid) begin
        last_grant  <= gnt_id;
        cur_id      <= gnt_id;
        cur_we      <= sel_we;
        cur_size    <= sel_size;
        cur_uns     <= sel_uns;
        cur_err     <= ~sel_in_win;
        per_address <= sel_addr;
        per_data_in <= sel_wdata;
        if (gnt_id) rdata1 <= '0;
        else        rdata0 <= '0;
      end
      if (state == ST_WAIT && !cur_we) begin
        if (cur_id) rdata1 <= per_data_out;
        else        rdata0 <= per_data_out;
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ack0             = 1'b0;
    ack1             = 1'b0;
    err0             = 1'b0;
    err1             = 1'b0;
    per_state        = 3'd0;
    per_enabled      = 1'b0;
    per_load_enable  = 1'b0;
    per_store_enable = 1'b0;
    per_is_lb        = 1'b0;
    per_is_lbu       = 1'b0;
    per_is_lh        = 1'b0;
    per_is_lhu       = 1'b0;
    per_is_lw        = 1'b0;
    per_is_sb        = 1'b0;
    per_is_sh        = 1'b0;
    per_is_sw        = 1'b0;
    case (state)
      ST_ISSUE: begin
        per_state        = EXEC_STATE;
        per_enabled      = 1'b1;
        per_load_enable  = ~cur_we;
        per_store_enable = cur_we;
        case (cur_size)
          SZ_B: begin
            per_is_sb  = cur_we;
            per_is_lbu = ~cur_we & cur_uns;
            per_is_lb  = ~cur_we & ~cur_uns;
          end
          SZ_H: begin
            per_is_sh  = cur_we;
            per_is_lhu = ~cur_we & cur_uns;
            per_is_lh  = ~cur_we & ~cur_uns;
          end
          default: begin
            per_is_sw = cur_we;
            per_is_lw = ~cur_we;
          end
        endcase
      end
      ST_RESP: begin
        ack0 = ~cur_id;
        ack1 = cur_id;
        err0 = ~cur_id & cur_err;
        err1 = cur_id & cur_err;
      end
      default: ;
    endcase
  end

endmodule
